// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared states, stage indices and hazard causes for the stall/flush controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, DC_WAIT = 2'd2, IC_WAIT = 2'd3} state_t;
  typedef enum logic [2:0] {CAUSE_NONE, CAUSE_IC, CAUSE_DC, CAUSE_LU, CAUSE_BR} cause_t;
  localparam int IFID = 0;
  localparam int IDEX = 1;
  localparam int EXMEM = 2;
  localparam int LU_W = 2;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stage controls; perf ports exist only with PIPE_HAZARD_PERF_EN
interface pipe_hazard_ctrl_if #(parameter int NSTAGES = 4, parameter int REG_W = 5);
  logic ic_miss;
  logic dc_miss;
  logic [REG_W-1:0] dec_rs_a;
  logic [REG_W-1:0] dec_rs_b;
  logic dec_uses_b;
  logic ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic br_taken;
  logic pc_en;
  logic [NSTAGES-1:0] en;
  logic [NSTAGES-1:0] bubble;
  logic stall_timeout;
  logic [1:0] dbg_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic perf_clr;
  logic [31:0] perf_ic, perf_dc, perf_lu, perf_br;
`endif
  modport master(
    output ic_miss, dc_miss, dec_rs_a, dec_rs_b, dec_uses_b, ex_is_load, ex_rd, br_taken,
    input pc_en, en, bubble, stall_timeout, dbg_state
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_clr, input perf_ic, perf_dc, perf_lu, perf_br
`endif
  );
  modport slave(
    input ic_miss, dc_miss, dec_rs_a, dec_rs_b, dec_uses_b, ex_is_load, ex_rd, br_taken,
    output pc_en, en, bubble, stall_timeout, dbg_state
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_clr, output perf_ic, perf_dc, perf_lu, perf_br
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles, raises a sticky timeout at MAX_STALL
module stall_watchdog #(parameter int MAX_STALL = 1023) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic timeout
);
  localparam int W = $clog2(MAX_STALL + 1);
  logic [W-1:0] cnt;
  // saturating run-length counter; timeout latches on the edge the count reaches MAX_STALL
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= !stall ? '0 : (cnt == W'(MAX_STALL)) ? cnt : cnt + 1'b1;
      timeout <= timeout | (stall && cnt == W'(MAX_STALL - 1));
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the in-order core; PIPE_HAZARD_PERF_EN adds cause counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES = 4,
  parameter int REG_W = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MAX_STALL = 1023
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [REG_W-1:0] R0 = '0;
  state_t state, state_nx;
  cause_t cause;
  logic [LU_W-1:0] lu_cnt, lu_cnt_nx;
  logic [NSTAGES-1:0] en_v, bubble_v;
  logic pc_en_v, lu_det, lu_pend;
  assign lu_det = bus.ex_is_load && bus.ex_rd != R0 &&
                  (bus.ex_rd == bus.dec_rs_a || (bus.dec_uses_b && bus.ex_rd == bus.dec_rs_b));
  // a non-zero count means load-use bubbles are still owed, even across a D-cache wait
  assign lu_pend = lu_cnt != '0;
  assign cause = bus.dc_miss ? CAUSE_DC : bus.br_taken ? CAUSE_BR :
                 (lu_det || lu_pend) ? CAUSE_LU : bus.ic_miss ? CAUSE_IC : CAUSE_NONE;
  // stage controls and next state from the winning hazard; reset forces every stage to load a NOP
  always_comb begin
    en_v = '1;
    bubble_v = '0;
    pc_en_v = 1'b1;
    state_nx = RUN;
    lu_cnt_nx = lu_cnt;
    if (reset) begin
      bubble_v = '1;
      pc_en_v = 1'b0;
      lu_cnt_nx = '0;
    end else begin
      case (cause)
        CAUSE_DC: begin
          en_v = '0;
          pc_en_v = 1'b0;
          state_nx = DC_WAIT;
        end
        CAUSE_BR: begin
          bubble_v[IFID] = 1'b1;
          bubble_v[IDEX] = 1'b1;
          lu_cnt_nx = '0;
        end
        CAUSE_LU: begin
          en_v[IFID] = 1'b0;
          pc_en_v = 1'b0;
          bubble_v[IDEX] = 1'b1;
          lu_cnt_nx = lu_pend ? lu_cnt - LU_W'(1) : LU_W'(LOAD_USE_CYCLES - 1);
          state_nx = lu_cnt_nx != '0 ? LU_STALL : RUN;
        end
        CAUSE_IC: begin
          pc_en_v = 1'b0;
          bubble_v[IFID] = 1'b1;
          state_nx = IC_WAIT;
        end
        default: ;
      endcase
    end
  end
  // state and load-use count registers; reset values come through the next-state logic
  always_ff @(posedge clk) begin
    state <= state_nx;
    lu_cnt <= lu_cnt_nx;
  end
  assign bus.en = en_v;
  assign bus.bubble = bubble_v;
  assign bus.pc_en = pc_en_v;
  assign bus.dbg_state = state;
  stall_watchdog #(.MAX_STALL(MAX_STALL)) u_wd (
    .clk(clk),
    .reset(reset),
    .stall(!pc_en_v),
    .timeout(bus.stall_timeout)
  );
`ifdef PIPE_HAZARD_PERF_EN
  // per-cause cycle counters; clear wins over an increment in the same cycle
  always_ff @(posedge clk) begin
    if (reset || bus.perf_clr) begin
      bus.perf_ic <= '0;
      bus.perf_dc <= '0;
      bus.perf_lu <= '0;
      bus.perf_br <= '0;
    end else begin
      bus.perf_ic <= bus.perf_ic + 32'(cause == CAUSE_IC);
      bus.perf_dc <= bus.perf_dc + 32'(cause == CAUSE_DC);
      bus.perf_lu <= bus.perf_lu + 32'(cause == CAUSE_LU);
      bus.perf_br <= bus.perf_br + 32'(cause == CAUSE_BR);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-level reference model of the hazard rules
module tb_pipe_hazard_ctrl;
  localparam int NS = 4;
  localparam int LUC = 2;
  localparam int MAXS = 8;
  typedef struct {
    logic pc;
    logic [NS-1:0] en;
    logic [NS-1:0] bub;
    logic to;
    logic [1:0] st;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int rem = 0;
  int lastst = 0;
  int scnt = 0;
  bit to = 1'b0;
  pipe_hazard_ctrl_if #(.NSTAGES(NS), .REG_W(5)) bus ();
  pipe_hazard_ctrl #(.NSTAGES(NS), .REG_W(5), .LOAD_USE_CYCLES(LUC), .MAX_STALL(MAXS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    bus.ic_miss = 0;
    bus.dc_miss = 0;
    bus.br_taken = 0;
    bus.ex_is_load = 0;
    bus.dec_uses_b = 0;
    bus.ex_rd = 0;
    bus.dec_rs_a = 0;
    bus.dec_rs_b = 0;
`ifdef PIPE_HAZARD_PERF_EN
    bus.perf_clr = 0;
`endif
  end
  // one clock of stimulus; the model owes "rem" extra load-use bubbles and tracks run length of stalls
  task automatic cyc(input bit r, ic, dc, br, ld, ub, input logic [4:0] rd, a, b);
    exp_t e;
    bit lu;
    int nst;
    @(posedge clk);
    #1;
    reset = r;
    bus.ic_miss = ic;
    bus.dc_miss = dc;
    bus.br_taken = br;
    bus.ex_is_load = ld;
    bus.dec_uses_b = ub;
    bus.ex_rd = rd;
    bus.dec_rs_a = a;
    bus.dec_rs_b = b;
    e.st = 2'(lastst);
    e.to = to;
    e.en = '1;
    e.bub = '0;
    e.pc = 1'b1;
    nst = 0;
    lu = ld && rd != 0 && (rd == a || (ub && rd == b));
    if (r) begin
      e.bub = '1;
      e.pc = 1'b0;
      rem = 0;
    end else if (dc) begin
      e.en = '0;
      e.pc = 1'b0;
      nst = 2;
    end else if (br) begin
      e.bub = 4'b0011;
      rem = 0;
    end else if (rem > 0 || lu) begin
      e.en = 4'b1110;
      e.pc = 1'b0;
      e.bub = 4'b0010;
      rem = rem > 0 ? rem - 1 : LUC - 1;
      nst = rem > 0 ? 1 : 0;
    end else if (ic) begin
      e.pc = 1'b0;
      e.bub = 4'b0001;
      nst = 3;
    end
    if (r) begin
      scnt = 0;
      to = 1'b0;
    end else if (e.pc) begin
      scnt = 0;
    end else begin
      scnt = scnt < MAXS ? scnt + 1 : MAXS;
      if (scnt == MAXS) to = 1'b1;
    end
    lastst = nst;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests += 5;
        if (bus.pc_en !== e.pc) begin
          fails++;
          $display("FAIL pc_en t=%0t got %b exp %b", $time, bus.pc_en, e.pc);
        end
        if (bus.en !== e.en) begin
          fails++;
          $display("FAIL en t=%0t got %b exp %b", $time, bus.en, e.en);
        end
        if (bus.bubble !== e.bub) begin
          fails++;
          $display("FAIL bubble t=%0t got %b exp %b", $time, bus.bubble, e.bub);
        end
        if (bus.stall_timeout !== e.to) begin
          fails++;
          $display("FAIL stall_timeout t=%0t got %b exp %b", $time, bus.stall_timeout, e.to);
        end
        if (bus.dbg_state !== e.st) begin
          fails++;
          $display("FAIL dbg_state t=%0t got %0d exp %0d", $time, bus.dbg_state, e.st);
        end
      end
    end
  end
  initial begin
    int w;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0, 7, 7, 3);
    cyc(0, 0, 0, 0, 1, 0, 7, 7, 3);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 9, 2, 9);
    cyc(0, 0, 0, 0, 1, 0, 9, 2, 9);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0, 5, 5, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 12,
          $urandom_range(99) < 10, $urandom_range(99) < 45, 1'($urandom),
          5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
